// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, IF/ID register
// with a one-entry skid buffer, decode stall and branch/jump redirect with kill.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
);
    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            outstanding_q, outstanding_d;
    logic            kill_q, kill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic            ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_d, ifid_instr_d;
    logic            fire;
    logic            accept;

    // A new request may overlap the response that retires the previous one.
    assign imem_req  = !rst && !redirect_valid && !skid_valid_q
                     && (!outstanding_q || imem_rvalid) && !(ifid_valid && stall);
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_gnt;
    assign accept    = imem_rvalid && !kill_q;

    // Next-state logic
    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        skid_valid_d  = skid_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        ifid_valid_d  = ifid_valid;
        ifid_pc_d     = ifid_pc;
        ifid_instr_d  = ifid_instr;

        if (redirect_valid) begin
            pc_d          = redirect_pc & ~XLEN'(3);
            ifid_valid_d  = 1'b0;
            ifid_instr_d  = NOP_INSTR;
            skid_valid_d  = 1'b0;
            // An in-flight response not yet returned belongs to the wrong path.
            kill_d        = outstanding_q && !imem_rvalid;
            outstanding_d = outstanding_q && !imem_rvalid;
        end else begin
            if (imem_rvalid) begin
                outstanding_d = 1'b0;
                kill_d        = 1'b0;
            end
            if (fire) begin
                outstanding_d = 1'b1;
                pc_d          = pc_q + XLEN'(4);
                req_pc_d      = pc_q;
            end
            if (accept) begin
                if (!ifid_valid || !stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = req_pc_q;
                    ifid_instr_d = imem_rdata;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_pc_d    = req_pc_q;
                    skid_instr_d = imem_rdata;
                end
            end else if (skid_valid_q && !stall) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = skid_pc_q;
                ifid_instr_d = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (!stall) begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= '0;
            skid_instr_q  <= NOP_INSTR;
            ifid_valid    <= 1'b0;
            ifid_pc       <= '0;
            ifid_instr    <= NOP_INSTR;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            ifid_valid    <= ifid_valid_d;
            ifid_pc       <= ifid_pc_d;
            ifid_instr    <= ifid_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed cycle table, randomized run against a
// stream-level reference model, and an asynchronous mid-fetch reset.
module tb_if_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] SIG    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    int errors = 0;
    int checks = 0;

    // Memory model: one pending response, returned mem_wait cycles after the grant cycle + 1.
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_wait;
    logic        mem_rand;

    // Pre-edge samples of the last tick
    logic        s_req, s_rv, s_busy;
    logic [31:0] s_addr;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        g;
        logic        hold;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[28];

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic g, input logic hold, input logic ereq,
                                input logic [31:0] eaddr, input logic ev, input logic [31:0] epc);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.g = g; v.hold = hold;
        v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after an edge, sample req, clock, return at edge+1.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic g, input logic hold);
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_gnt       = g;
        imem_rvalid    = mem_busy && (mem_wait == 0) && !hold;
        imem_rdata     = imem_rvalid ? (mem_addr ^ SIG) : 32'hDEAD_BEEF;
        #1;
        s_req  = imem_req;
        s_addr = imem_addr;
        s_rv   = imem_rvalid;
        s_busy = mem_busy;
        @(posedge clk);
        if (imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy && mem_wait != 0) mem_wait--;
        if (s_req && g) begin
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_wait = mem_rand ? int'($urandom_range(0, 2)) : 0;
        end
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc, fetch_pc, ppc, pinstr, rpc;
        logic        pv, st, rd, g;
        int          n_valid;

        //          st  rd  rpc           g  hold req addr          v  pc
        tbl[0]  = mk(0, 0, 32'h0,        1, 0,  1, 32'h100,      0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,        1, 0,  1, 32'h104,      1, 32'h100);
        tbl[2]  = mk(0, 0, 32'h0,        1, 0,  1, 32'h108,      1, 32'h104);
        tbl[3]  = mk(1, 0, 32'h0,        1, 0,  0, 32'h0,        1, 32'h104);
        tbl[4]  = mk(1, 0, 32'h0,        1, 0,  0, 32'h0,        1, 32'h104);
        tbl[5]  = mk(1, 0, 32'h0,        1, 0,  0, 32'h0,        1, 32'h104);
        tbl[6]  = mk(0, 0, 32'h0,        1, 0,  0, 32'h0,        1, 32'h108);
        tbl[7]  = mk(0, 0, 32'h0,        1, 0,  1, 32'h10C,      0, 32'h0);
        tbl[8]  = mk(0, 0, 32'h0,        1, 0,  1, 32'h110,      1, 32'h10C);
        tbl[9]  = mk(0, 1, 32'h203,      1, 1,  0, 32'h0,        0, 32'h0);
        tbl[10] = mk(0, 0, 32'h0,        1, 0,  1, 32'h200,      0, 32'h0);
        tbl[11] = mk(0, 0, 32'h0,        1, 0,  1, 32'h204,      1, 32'h200);
        tbl[12] = mk(0, 0, 32'h0,        1, 0,  1, 32'h208,      1, 32'h204);
        tbl[13] = mk(1, 0, 32'h0,        1, 0,  0, 32'h0,        1, 32'h204);
        tbl[14] = mk(1, 1, 32'h300,      1, 0,  0, 32'h0,        0, 32'h0);
        tbl[15] = mk(1, 0, 32'h0,        1, 0,  1, 32'h300,      0, 32'h0);
        tbl[16] = mk(0, 0, 32'h0,        1, 0,  1, 32'h304,      1, 32'h300);
        tbl[17] = mk(0, 0, 32'h0,        0, 0,  1, 32'h308,      1, 32'h304);
        tbl[18] = mk(0, 0, 32'h0,        0, 0,  1, 32'h308,      0, 32'h0);
        tbl[19] = mk(0, 0, 32'h0,        0, 0,  1, 32'h308,      0, 32'h0);
        tbl[20] = mk(0, 0, 32'h0,        0, 0,  1, 32'h308,      0, 32'h0);
        tbl[21] = mk(0, 0, 32'h0,        1, 0,  1, 32'h308,      0, 32'h0);
        tbl[22] = mk(0, 0, 32'h0,        1, 0,  1, 32'h30C,      1, 32'h308);
        tbl[23] = mk(0, 1, 32'hFFFF_FFFB, 1, 0, 0, 32'h0,        0, 32'h0);
        tbl[24] = mk(0, 0, 32'h0,        1, 0,  1, 32'hFFFF_FFF8, 0, 32'h0);
        tbl[25] = mk(0, 0, 32'h0,        1, 0,  1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8);
        tbl[26] = mk(0, 0, 32'h0,        1, 0,  1, 32'h0,        1, 32'hFFFF_FFFC);
        tbl[27] = mk(0, 0, 32'h0,        1, 0,  1, 32'h4,        1, 32'h0);

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        mem_busy = 1'b0; mem_addr = '0; mem_wait = 0; mem_rand = 1'b0;
        n_valid = 0; exp_pc = '0; fetch_pc = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(ifid_valid), 32'(1'b0));
        chk("reset_instr", ifid_instr, NOP);
        chk("reset_pc", ifid_pc, 32'h0);
        imem_gnt = 1'b1;
        #1;
        chk("reset_req", 32'(imem_req), 32'(1'b0));
        rst = 1'b0;

        // Directed cycle table: fill, stall with skid, kill, redirect+stall, gnt hold, wrap
        for (int i = 0; i < 28; i++) begin
            tick(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].g, tbl[i].hold);
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].ereq));
            if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d_valid", i), 32'(ifid_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_pc", i), ifid_pc, tbl[i].epc);
                chk($sformatf("tbl%0d_instr", i), ifid_instr, tbl[i].epc ^ SIG);
            end else begin
                chk($sformatf("tbl%0d_nop", i), ifid_instr, NOP);
            end
        end

        // Randomized run: decoded stream must be the program-order sequence from each redirect target
        mem_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            pv = ifid_valid; ppc = ifid_pc; pinstr = ifid_instr;
            st  = ($urandom_range(0, 3) == 0);
            rd  = (i == 0) || ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            g   = ($urandom_range(0, 3) != 0);
            tick(st, rd, rpc, g, 1'b0);
            if (s_req) begin
                chk("rnd_req_in_redirect", 32'(rd), 32'(1'b0));
                chk("rnd_req_two_outstanding", 32'(s_busy && !s_rv), 32'(1'b0));
                if (!rd) chk("rnd_fetch_addr", s_addr, fetch_pc);
            end
            if (rd) fetch_pc = rpc & 32'hFFFF_FFFC;
            else if (s_req && g) fetch_pc = fetch_pc + 32'd4;

            if (rd) begin
                chk("rnd_flush_valid", 32'(ifid_valid), 32'(1'b0));
                chk("rnd_flush_instr", ifid_instr, NOP);
                exp_pc = rpc & 32'hFFFF_FFFC;
            end else if (pv && st) begin
                chk("rnd_hold_valid", 32'(ifid_valid), 32'(1'b1));
                chk("rnd_hold_pc", ifid_pc, ppc);
                chk("rnd_hold_instr", ifid_instr, pinstr);
            end else if (ifid_valid) begin
                chk("rnd_stream_pc", ifid_pc, exp_pc);
                chk("rnd_stream_instr", ifid_instr, exp_pc ^ SIG);
                exp_pc = exp_pc + 32'd4;
                n_valid++;
            end else begin
                chk("rnd_bubble_instr", ifid_instr, NOP);
            end
        end
        chk("rnd_progress", 32'(n_valid > 100), 32'(1'b1));

        // Asynchronous reset while a fetch is outstanding
        mem_rand = 1'b0;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("pre_reset_outstanding", 32'(mem_busy), 32'(1'b1));
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ifid_valid), 32'(1'b0));
        chk("async_rst_instr", ifid_instr, NOP);
        chk("async_rst_pc", ifid_pc, 32'h0);
        chk("async_rst_req", 32'(imem_req), 32'(1'b0));
        mem_busy = 1'b0; mem_wait = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("restart_req", 32'(s_req), 32'(1'b1));
        chk("restart_addr", s_addr, RST_PC);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("restart_addr2", s_addr, RST_PC + 32'd4);
        chk("restart_valid", 32'(ifid_valid), 32'(1'b1));
        chk("restart_pc", ifid_pc, RST_PC);
        chk("restart_instr", ifid_instr, RST_PC ^ SIG);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
